// File: rtl/acc_cpu_core.sv
// acc_cpu_core: fetch/decode/execute controller for the 8-bit accumulator machine.
// Ports: clk, rst_n (async active-low); rom_adrs/rom_rd/rom_dout program ROM;
//   ram_adrs/ram_din/ram_wr/ram_rd/ram_dout data RAM; acc, pc, halted status.
// Optional: define CPU_CARRY_EN for the carry flag, carry port and jc opcode (07).
module acc_cpu_core #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         DW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [DW-1:0] rom_adrs,
  output logic          rom_rd,
  input  logic [DW-1:0] rom_dout,
  output logic [DW-1:0] ram_adrs,
  output logic [DW-1:0] ram_din,
  output logic          ram_wr,
  output logic          ram_rd,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] acc,
  output logic [DW-1:0] pc,
`ifdef CPU_CARRY_EN
  output logic          carry,
`endif
  output logic          halted
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_LD   = 8'h02;
  localparam logic [7:0] OP_ADDI = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_ST   = 8'h05;
  localparam logic [7:0] OP_JMP  = 8'h06;
`ifdef CPU_CARRY_EN
  localparam logic [7:0] OP_JC   = 8'h07;
`endif

  typedef enum logic [1:0] {
    S_FETCH_OP,
    S_FETCH_ARG,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  arg_q, arg_d;
  logic [7:0]  ram_adrs_q, ram_adrs_d;
  logic [7:0]  ram_din_q, ram_din_d;
  logic        ram_wr_q, ram_wr_d;
  logic        ram_rd_q, ram_rd_d;
  logic        halted_q, halted_d;
  logic [7:0]  addend;
`ifdef CPU_CARRY_EN
  logic        carry_q, carry_d;
  logic [8:0]  sum;
`else
  logic [7:0]  sum;
`endif

  // RAM strobes are registered: they are set up while the operand is
  // fetched (opcode already known) so they are clean for the whole S_EXEC.
  logic op_rd;
  logic op_wr;
  assign op_rd = (op_q == OP_LD) || (op_q == OP_ADD);
  assign op_wr = (op_q == OP_ST);

  assign addend = (op_q == OP_ADD) ? ram_dout : arg_q;
`ifdef CPU_CARRY_EN
  assign sum = {1'b0, acc_q} + {1'b0, addend};
`else
  assign sum = acc_q + addend;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    op_d       = op_q;
    arg_d      = arg_q;
    ram_adrs_d = ram_adrs_q;
    ram_din_d  = ram_din_q;
    ram_wr_d   = 1'b0;
    ram_rd_d   = 1'b0;
    halted_d   = halted_q;
`ifdef CPU_CARRY_EN
    carry_d    = carry_q;
`endif
    unique case (state_q)
      S_FETCH_OP: begin
        op_d    = rom_dout;
        pc_d    = pc_q + 8'd1;
        state_d = S_FETCH_ARG;
      end
      S_FETCH_ARG: begin
        arg_d   = rom_dout;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
        if (op_rd || op_wr) begin
          ram_adrs_d = rom_dout;
          ram_din_d  = acc_q;
        end
        ram_rd_d = op_rd;
        ram_wr_d = op_wr;
      end
      S_EXEC: begin
        state_d = S_FETCH_OP;
        case (op_q)
          OP_NOP: ;
          OP_LDI: begin
            acc_d = arg_q;
`ifdef CPU_CARRY_EN
            carry_d = 1'b0;
`endif
          end
          OP_LD: begin
            acc_d = ram_dout;
`ifdef CPU_CARRY_EN
            carry_d = 1'b0;
`endif
          end
          OP_ADDI, OP_ADD: begin
            acc_d = sum[7:0];
`ifdef CPU_CARRY_EN
            carry_d = sum[8];
`endif
          end
          OP_ST: ;
          OP_JMP: pc_d = arg_q;
`ifdef CPU_CARRY_EN
          OP_JC: if (carry_q) pc_d = arg_q;
`endif
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        endcase
      end
      S_HALT: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH_OP;
      pc_q       <= RESET_PC;
      acc_q      <= 8'h00;
      op_q       <= 8'h00;
      arg_q      <= 8'h00;
      ram_adrs_q <= 8'h00;
      ram_din_q  <= 8'h00;
      ram_wr_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      halted_q   <= 1'b0;
`ifdef CPU_CARRY_EN
      carry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      ram_adrs_q <= ram_adrs_d;
      ram_din_q  <= ram_din_d;
      ram_wr_q   <= ram_wr_d;
      ram_rd_q   <= ram_rd_d;
      halted_q   <= halted_d;
`ifdef CPU_CARRY_EN
      carry_q    <= carry_d;
`endif
    end
  end

  // Reset parks the FSM in S_FETCH_OP; gating keeps the ROM idle until release.
  assign rom_rd   = rst_n &
                    ((state_q == S_FETCH_OP) || (state_q == S_FETCH_ARG));
  assign rom_adrs = pc_q;
  assign ram_adrs = ram_adrs_q;
  assign ram_din  = ram_din_q;
  assign ram_wr   = ram_wr_q;
  assign ram_rd   = ram_rd_q;
  assign acc      = acc_q;
  assign pc       = pc_q;
  assign halted   = halted_q;
`ifdef CPU_CARRY_EN
  assign carry    = carry_q;
`endif

endmodule
